// File: rtl/soc_mmio_io_pkg.sv
// Shared definitions for the soc_mmio_io register block: word offsets,
// SCANCTRL bit positions and the bus data type.
package soc_mmio_io_pkg;
  typedef logic [31:0] bus_data_t;

  localparam logic [2:0] OFF_LEDCOL0  = 3'd0;
  localparam logic [2:0] OFF_KEYSTATE = 3'd4;
  localparam logic [2:0] OFF_KEYPRESS = 3'd5;
  localparam logic [2:0] OFF_SCANCTRL = 3'd6;
  localparam logic [2:0] OFF_RSVD     = 3'd7;

  localparam int SC_EN_BIT  = 0;
  localparam int SC_INV_BIT = 1;
endpackage

// File: rtl/soc_mmio_io_key_debounce.sv
// Single-key debouncer: 2-flop synchroniser, stability counter, debounced
// level (1 = pressed) and a one-cycle pulse in the first pressed cycle.
module key_debounce #(
  parameter int DEB_CYCLES = 12000
) (
  input  logic clk,
  input  logic rst,
  input  logic key_n,
  output logic state,
  output logic press
);
  localparam int CNT_W = $clog2(DEB_CYCLES + 1);

  logic             sync1_q, sync1_d, sync2_q, sync2_d;
  logic             state_q, state_d, press_q, press_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  // Counter only runs while the synchronised level disagrees with the
  // debounced state; any agreeing cycle drops it back to zero.
  always_comb begin
    sync1_d = ~key_n;
    sync2_d = sync1_q;
    state_d = state_q;
    press_d = 1'b0;
    cnt_d   = '0;
    if (sync2_q != state_q) begin
      if (cnt_q == CNT_W'(DEB_CYCLES - 1)) begin
        state_d = ~state_q;
        press_d = ~state_q;
      end else begin
        cnt_d = cnt_q + CNT_W'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
      state_q <= 1'b0;
      press_q <= 1'b0;
      cnt_q   <= '0;
    end else begin
      sync1_q <= sync1_d;
      sync2_q <= sync2_d;
      state_q <= state_d;
      press_q <= press_d;
      cnt_q   <= cnt_d;
    end
  end

  assign state = state_q;
  assign press = press_q;
endmodule

// File: rtl/soc_mmio_io.sv
// MMIO LED-matrix scanner and debounced key block on a simple valid/done bus.
// Define SOC_MMIO_IO_KEYLATCH_EN to build the write-1-to-clear KEYPRESS latch.
module soc_mmio_io
  import soc_mmio_io_pkg::*;
#(
  parameter int          NCOL       = 4,
  parameter int          NKEYS      = 4,
  parameter logic [31:0] BASE_ADDR  = 32'h0000_1000,
  parameter int          DEB_CYCLES = 12000,
  parameter int          SCAN_DIV   = 1024
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             mem_valid,
  input  logic [31:0]      mem_addr,
  input  logic [31:0]      mem_wdata,
  input  logic             mem_wstrobe,
  output logic [31:0]      mem_rdata,
  output logic             mem_done,
  input  logic [NKEYS-1:0] keys_n,
  output logic [7:0]       leds_n,
  output logic [NCOL-1:0]  lcol_n
);
  localparam int DIV_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;

  logic             hit, wr, en;
  logic [2:0]       off;
  logic [7:0]       ledcol_q [4];
  logic [7:0]       ledcol_d [4];
  logic [1:0]       scanctrl_q, scanctrl_d;
  logic             done_q;
  bus_data_t        rdata_q, rdata_d;
  logic [DIV_W-1:0] div_q, div_d;
  logic [1:0]       col_q, col_d;
  logic [NKEYS-1:0] keystate, press, keypress_rd;
  logic             unused_bits;

  assign hit = mem_valid && (mem_addr[31:5] == BASE_ADDR[31:5]);
  assign wr  = hit && mem_wstrobe;
  assign off = mem_addr[4:2];
  assign en  = scanctrl_q[SC_EN_BIT];
  assign unused_bits = ^{mem_addr[1:0], mem_wdata[31:8]};

  for (genvar i = 0; i < NKEYS; i++) begin : g_key
    key_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_deb (
      .clk   (clk),
      .rst   (rst),
      .key_n (keys_n[i]),
      .state (keystate[i]),
      .press (press[i])
    );
  end

`ifdef SOC_MMIO_IO_KEYLATCH_EN
  logic [NKEYS-1:0] keypress_q, keypress_d;

  // Press is OR-ed after the clear so a same-cycle event survives the W1C.
  always_comb begin
    keypress_d = keypress_q;
    if (wr && off == OFF_KEYPRESS) keypress_d = keypress_d & ~mem_wdata[NKEYS-1:0];
    keypress_d = keypress_d | press;
  end

  always_ff @(posedge clk) begin
    if (rst) keypress_q <= '0;
    else     keypress_q <= keypress_d;
  end

  assign keypress_rd = keypress_q;
`else
  logic unused_press;
  assign unused_press = ^press;
  assign keypress_rd  = '0;
`endif

  always_comb begin
    ledcol_d   = ledcol_q;
    scanctrl_d = scanctrl_q;
    rdata_d    = '0;
    if (wr) begin
      if (off < OFF_KEYSTATE && int'(off) < NCOL) ledcol_d[off[1:0]] = mem_wdata[7:0];
      if (off == OFF_SCANCTRL) scanctrl_d = mem_wdata[1:0];
    end
    if (hit && !mem_wstrobe) begin
      if (off < OFF_KEYSTATE) begin
        if (int'(off) < NCOL) rdata_d[7:0] = ledcol_q[off[1:0]];
      end else if (off == OFF_KEYSTATE) begin
        rdata_d[NKEYS-1:0] = keystate;
      end else if (off == OFF_KEYPRESS) begin
        rdata_d[NKEYS-1:0] = keypress_rd;
      end else if (off == OFF_SCANCTRL) begin
        rdata_d[1:0] = scanctrl_q;
      end
    end
  end

  // Column dwell: divider and column sit at zero while scanning is off.
  always_comb begin
    div_d = div_q;
    col_d = col_q;
    if (!en) begin
      div_d = '0;
      col_d = '0;
    end else if (div_q == DIV_W'(SCAN_DIV - 1)) begin
      div_d = '0;
      col_d = (col_q == 2'(NCOL - 1)) ? 2'd0 : col_q + 2'd1;
    end else begin
      div_d = div_q + DIV_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < 4; i++) ledcol_q[i] <= '0;
      scanctrl_q <= '0;
      done_q     <= 1'b0;
      rdata_q    <= '0;
      div_q      <= '0;
      col_q      <= '0;
    end else begin
      ledcol_q   <= ledcol_d;
      scanctrl_q <= scanctrl_d;
      done_q     <= hit;
      rdata_q    <= rdata_d;
      div_q      <= div_d;
      col_q      <= col_d;
    end
  end

  assign mem_done  = done_q;
  assign mem_rdata = rdata_q;
  assign lcol_n    = en ? ~(NCOL'(1) << col_q) : '1;
  assign leds_n    = (!en || div_q == '0) ? 8'hFF
                   : ~(ledcol_q[col_q] ^ {8{scanctrl_q[SC_INV_BIT]}});
endmodule

// File: tb/tb_soc_mmio_io.sv
// Bench for soc_mmio_io: a 4-column and a 2-column instance share one bus and
// key inputs; expectations come from a register-level model of the block.
module tb_soc_mmio_io;
  localparam int          NKEYS = 4;
  localparam int          DEB   = 8;
  localparam int          SDIV  = 4;
  localparam logic [31:0] BASE  = 32'h0000_1000;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             mem_valid = 1'b0, mem_wstrobe = 1'b0;
  logic [31:0]      mem_addr = '0, mem_wdata = '0;
  logic [NKEYS-1:0] keys_n = '1;
  logic [31:0]      rdata_a, rdata_b;
  logic             done_a, done_b;
  logic [7:0]       leds_a, leds_b;
  logic [3:0]       lcol_a;
  logic [1:0]       lcol_b;

  int total = 0;
  int bad   = 0;

  logic [7:0]       m_led [4];
  logic [1:0]       m_scan;
  logic [NKEYS-1:0] m_kp, m_ks;

  soc_mmio_io #(.NCOL(4), .NKEYS(NKEYS), .BASE_ADDR(BASE), .DEB_CYCLES(DEB), .SCAN_DIV(SDIV)) dut_a (
    .clk(clk), .rst(rst), .mem_valid(mem_valid), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_wstrobe(mem_wstrobe), .mem_rdata(rdata_a), .mem_done(done_a), .keys_n(keys_n),
    .leds_n(leds_a), .lcol_n(lcol_a));

  soc_mmio_io #(.NCOL(2), .NKEYS(NKEYS), .BASE_ADDR(BASE), .DEB_CYCLES(DEB), .SCAN_DIV(SDIV)) dut_b (
    .clk(clk), .rst(rst), .mem_valid(mem_valid), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_wstrobe(mem_wstrobe), .mem_rdata(rdata_b), .mem_done(done_b), .keys_n(keys_n),
    .leds_n(leds_b), .lcol_n(lcol_b));

  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog time limit reached total=%0d bad=%0d", total, bad);
    $fatal(1, "watchdog");
  end

  function automatic logic [31:0] exp_read(input int ncol, input int offs);
    logic [31:0] r;
    r = '0;
    if (offs < 4) begin
      if (offs < ncol) r[7:0] = m_led[offs];
    end else if (offs == 4) begin
      r[NKEYS-1:0] = m_ks;
    end else if (offs == 5) begin
`ifdef SOC_MMIO_IO_KEYLATCH_EN
      r[NKEYS-1:0] = m_kp;
`endif
    end else if (offs == 6) begin
      r[1:0] = m_scan;
    end
    return r;
  endfunction

  function automatic void m_write(input int offs, input logic [31:0] wd);
    if (offs < 4) m_led[offs] = wd[7:0];
    else if (offs == 5) m_kp = m_kp & ~wd[NKEYS-1:0];
    else if (offs == 6) m_scan = wd[1:0];
  endfunction

  // One bus transaction: request held across exactly one rising edge,
  // outputs captured on the following falling edge.
  task automatic xfer(input logic [31:0] addr, input logic wr, input logic [31:0] wd,
                      output logic [31:0] ra, output logic da, output logic [31:0] rb, output logic db);
    @(negedge clk);
    mem_valid = 1'b1; mem_addr = addr; mem_wstrobe = wr; mem_wdata = wd;
    @(negedge clk);
    ra = rdata_a; da = done_a; rb = rdata_b; db = done_b;
    mem_valid = 1'b0; mem_wstrobe = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    total++;
    if ({done_a, rdata_a, lcol_a, leds_a} !== {1'b0, 32'h0, 4'hF, 8'hFF}) begin
      bad++; $display("FAIL reset_a got done=%b rdata=%h lcol=%b leds=%h exp 0/0/1111/ff", done_a, rdata_a, lcol_a, leds_a);
    end
    total++;
    if ({done_b, rdata_b, lcol_b, leds_b} !== {1'b0, 32'h0, 2'b11, 8'hFF}) begin
      bad++; $display("FAIL reset_b got done=%b rdata=%h lcol=%b leds=%h exp 0/0/11/ff", done_b, rdata_b, lcol_b, leds_b);
    end
    rst = 1'b0;
    for (int i = 0; i < 4; i++) m_led[i] = '0;
    m_scan = '0; m_kp = '0; m_ks = '0;
  endtask

  task automatic test_ledcol_rw();
    logic [31:0] ra, rb; logic da, db;
    xfer(BASE, 1'b1, 32'h0000_00A5, ra, da, rb, db);
    m_write(0, 32'hA5);
    total++;
    if (da !== 1'b1) begin bad++; $display("FAIL wr_done got=%b exp=1", da); end
    xfer(BASE, 1'b0, 32'h0, ra, da, rb, db);
    total++;
    if ({da, ra} !== {1'b1, 32'h0000_00A5}) begin
      bad++; $display("FAIL rd_ledcol0 got done=%b data=%h exp done=1 data=000000a5", da, ra);
    end
    // Request held for three edges: one done per hit cycle.
    @(negedge clk);
    mem_valid = 1'b1; mem_addr = BASE; mem_wstrobe = 1'b0;
    total++;
    if ({done_a, rdata_a} !== {1'b0, 32'h0}) begin
      bad++; $display("FAIL held_pre got done=%b data=%h exp 0/0", done_a, rdata_a);
    end
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      if (k == 2) mem_valid = 1'b0;
      total++;
      if ({done_a, rdata_a} !== {1'b1, 32'hA5}) begin
        bad++; $display("FAIL held_hit%0d got done=%b data=%h exp 1/a5", k, done_a, rdata_a);
      end
    end
    @(negedge clk);
    total++;
    if ({done_a, rdata_a} !== {1'b0, 32'h0}) begin
      bad++; $display("FAIL held_post got done=%b data=%h exp 0/0", done_a, rdata_a);
    end
  endtask

  task automatic test_random_regs();
    logic [31:0] ra, rb, addr, wd; logic da, db, wr, miss; int offs;
    for (int n = 0; n < 60; n++) begin
      offs = int'($urandom_range(7));
      wr   = 1'($urandom_range(1));
      wd   = $urandom;
      miss = ($urandom_range(4) == 0);
      addr = miss ? BASE + (32'h20 << $urandom_range(8))
                  : BASE + 32'(offs * 4) + 32'($urandom_range(3));
      xfer(addr, wr, wd, ra, da, rb, db);
      if (miss) begin
        total++;
        if ({da, ra, db, rb} !== '0) begin
          bad++; $display("FAIL rnd_miss addr=%h got done=%b/%b data=%h/%h exp none", addr, da, db, ra, rb);
        end
      end else if (wr) begin
        m_write(offs, wd);
        total++;
        if ({da, db} !== 2'b11) begin bad++; $display("FAIL rnd_wr off=%0d got done=%b%b exp 11", offs, da, db); end
      end else begin
        total++;
        if ({da, ra} !== {1'b1, exp_read(4, offs)}) begin
          bad++; $display("FAIL rnd_rd_a off=%0d got %b/%h exp 1/%h", offs, da, ra, exp_read(4, offs));
        end
        total++;
        if ({db, rb} !== {1'b1, exp_read(2, offs)}) begin
          bad++; $display("FAIL rnd_rd_b off=%0d got %b/%h exp 1/%h", offs, db, rb, exp_read(2, offs));
        end
      end
    end
    xfer(BASE + 32'h18, 1'b1, 32'h0, ra, da, rb, db);
    m_write(6, 32'h0);
  endtask

  task automatic test_scan();
    logic [31:0] ra, rb; logic da, db; logic inv; int ca, cb; logic first;
    logic [7:0] ea, eb;
    for (int i = 0; i < 4; i++) begin
      xfer(BASE + 32'(i * 4), 1'b1, 32'($urandom_range(255)), ra, da, rb, db);
      m_write(i, mem_wdata);
    end
    inv = 1'($urandom_range(1));
    xfer(BASE + 32'h18, 1'b1, {30'h0, inv, 1'b1}, ra, da, rb, db);
    m_write(6, {30'h0, inv, 1'b1});
    for (int k = 0; k < 2 * 4 * SDIV; k++) begin
      if (k > 0) @(negedge clk);
      ca = (k / SDIV) % 4;
      cb = (k / SDIV) % 2;
      first = (k % SDIV) == 0;
      ea = first ? 8'hFF : ~(m_led[ca] ^ {8{inv}});
      eb = first ? 8'hFF : ~(m_led[cb] ^ {8{inv}});
      total++;
      if ({lcol_a, leds_a} !== {~(4'b0001 << ca), ea}) begin
        bad++; $display("FAIL scan_a k=%0d got lcol=%b leds=%h exp lcol=%b leds=%h", k, lcol_a, leds_a, ~(4'b0001 << ca), ea);
      end
      total++;
      if ({lcol_b, leds_b} !== {~(2'b01 << cb), eb}) begin
        bad++; $display("FAIL scan_b k=%0d got lcol=%b leds=%h exp lcol=%b leds=%h", k, lcol_b, leds_b, ~(2'b01 << cb), eb);
      end
    end
    xfer(BASE + 32'h18, 1'b1, 32'h0, ra, da, rb, db);
    m_write(6, 32'h0);
    repeat (3) @(negedge clk);
    total++;
    if ({lcol_a, leds_a, lcol_b, leds_b} !== {4'hF, 8'hFF, 2'b11, 8'hFF}) begin
      bad++; $display("FAIL scan_off got lcol=%b/%b leds=%h/%h exp all ones", lcol_a, lcol_b, leds_a, leds_b);
    end
  endtask

  task automatic test_ncol2();
    logic [31:0] ra, rb; logic da, db;
    xfer(BASE + 32'h0C, 1'b1, 32'hFF, ra, da, rb, db);
    m_write(3, 32'hFF);
    xfer(BASE + 32'h0C, 1'b0, 32'h0, ra, da, rb, db);
    total++;
    if ({da, ra} !== {1'b1, exp_read(4, 3)}) begin bad++; $display("FAIL ncol4_col3 got %b/%h exp 1/%h", da, ra, exp_read(4, 3)); end
    total++;
    if ({db, rb} !== {1'b1, exp_read(2, 3)}) begin bad++; $display("FAIL ncol2_col3 got %b/%h exp 1/%h", db, rb, exp_read(2, 3)); end
    xfer(BASE + 32'h20, 1'b0, 32'h0, ra, da, rb, db);
    total++;
    if ({da, db, ra, rb} !== '0) begin bad++; $display("FAIL out_of_window_rd got done=%b%b data=%h/%h exp none", da, db, ra, rb); end
    xfer(BASE + 32'h20, 1'b1, 32'h55, ra, da, rb, db);
    total++;
    if ({da, db} !== 2'b00) begin bad++; $display("FAIL out_of_window_wr got done=%b%b exp 00", da, db); end
  endtask

  task automatic test_debounce();
    logic [31:0] ra, rb; logic da, db;
    @(negedge clk); keys_n[0] = 1'b0;
    repeat (DEB - 1) @(negedge clk);
    keys_n[0] = 1'b1;
    repeat (6) @(negedge clk);
    xfer(BASE + 32'h10, 1'b0, 32'h0, ra, da, rb, db);
    total++;
    if ({da, ra} !== {1'b1, exp_read(4, 4)}) begin bad++; $display("FAIL deb_short got %b/%h exp 1/%h", da, ra, exp_read(4, 4)); end
    // A full DEB-cycle hold flips the state two synchroniser cycles later.
    @(negedge clk); keys_n[0] = 1'b0;
    repeat (DEB) @(negedge clk);
    keys_n[0] = 1'b1;
    m_ks[0] = 1'b1; m_kp[0] = 1'b1;
    repeat (2) @(negedge clk);
    xfer(BASE + 32'h10, 1'b0, 32'h0, ra, da, rb, db);
    total++;
    if ({da, ra} !== {1'b1, exp_read(4, 4)}) begin bad++; $display("FAIL deb_full got %b/%h exp 1/%h", da, ra, exp_read(4, 4)); end
    repeat (20) @(negedge clk);
    m_ks[0] = 1'b0;
    xfer(BASE + 32'h10, 1'b0, 32'h0, ra, da, rb, db);
    total++;
    if ({da, ra} !== {1'b1, exp_read(4, 4)}) begin bad++; $display("FAIL deb_release got %b/%h exp 1/%h", da, ra, exp_read(4, 4)); end
    xfer(BASE + 32'h14, 1'b0, 32'h0, ra, da, rb, db);
    total++;
    if ({da, ra} !== {1'b1, exp_read(4, 5)}) begin bad++; $display("FAIL keypress_k0 got %b/%h exp 1/%h", da, ra, exp_read(4, 5)); end
  endtask

  task automatic test_keypress();
    logic [31:0] ra, rb; logic da, db;
    xfer(BASE + 32'h14, 1'b1, 32'hFF, ra, da, rb, db);
    m_write(5, 32'hFF);
    @(negedge clk); keys_n[2] = 1'b0;
    // Press event falls in the cycle after edge 2+DEB; the W1C hits that cycle.
    repeat (DEB + 1) @(negedge clk);
    xfer(BASE + 32'h14, 1'b1, 32'h4, ra, da, rb, db);
    m_write(5, 32'h4);
    m_kp[2] = 1'b1; m_ks[2] = 1'b1;
    xfer(BASE + 32'h14, 1'b0, 32'h0, ra, da, rb, db);
    total++;
    if ({da, ra} !== {1'b1, exp_read(4, 5)}) begin bad++; $display("FAIL kp_set_wins got %b/%h exp 1/%h", da, ra, exp_read(4, 5)); end
    xfer(BASE + 32'h10, 1'b0, 32'h0, ra, da, rb, db);
    total++;
    if ({da, ra} !== {1'b1, exp_read(4, 4)}) begin bad++; $display("FAIL kp_keystate got %b/%h exp 1/%h", da, ra, exp_read(4, 4)); end
    xfer(BASE + 32'h14, 1'b1, 32'h4, ra, da, rb, db);
    m_write(5, 32'h4);
    xfer(BASE + 32'h14, 1'b0, 32'h0, ra, da, rb, db);
    total++;
    if ({da, ra} !== {1'b1, exp_read(4, 5)}) begin bad++; $display("FAIL kp_cleared got %b/%h exp 1/%h", da, ra, exp_read(4, 5)); end
    keys_n[2] = 1'b1;
    repeat (DEB + 6) @(negedge clk);
    m_ks[2] = 1'b0;
  endtask

  task automatic test_reset_pending();
    logic [31:0] ra, rb; logic da, db;
    xfer(BASE + 32'h04, 1'b1, 32'h3C, ra, da, rb, db);
    xfer(BASE + 32'h18, 1'b1, 32'h3, ra, da, rb, db);
    @(negedge clk);
    mem_valid = 1'b1; mem_addr = BASE + 32'h04; mem_wstrobe = 1'b0; rst = 1'b1;
    @(negedge clk);
    mem_valid = 1'b0; rst = 1'b0;
    total++;
    if ({done_a, done_b, rdata_a, rdata_b} !== '0) begin
      bad++; $display("FAIL rst_cancel got done=%b%b data=%h/%h exp none", done_a, done_b, rdata_a, rdata_b);
    end
    for (int i = 0; i < 4; i++) m_led[i] = '0;
    m_scan = '0; m_kp = '0;
    for (int offs = 0; offs < 8; offs++) begin
      xfer(BASE + 32'(offs * 4), 1'b0, 32'h0, ra, da, rb, db);
      total++;
      if ({da, ra, db, rb} !== {1'b1, exp_read(4, offs), 1'b1, exp_read(2, offs)}) begin
        bad++; $display("FAIL post_rst_rd off=%0d got %b/%h %b/%h exp 1/%h", offs, da, ra, db, rb, exp_read(4, offs));
      end
    end
    total++;
    if ({lcol_a, leds_a} !== {4'hF, 8'hFF}) begin bad++; $display("FAIL post_rst_outs got lcol=%b leds=%h exp 1111/ff", lcol_a, leds_a); end
  endtask

  initial begin
    test_reset();
    test_ledcol_rw();
    test_random_regs();
    test_scan();
    test_ncol2();
    test_debounce();
    test_keypress();
    test_reset_pending();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/soc_mmio_io.md
SOC_MMIO_IO -- requirements
Module: soc_mmio_io

Interface
REQ-001 SHALL have parameter NCOL, default 4, number of LED columns scanned (1..4).
REQ-002 SHALL have parameter NKEYS, default 4, number of debounced key inputs (1..8).
REQ-003 SHALL have parameter BASE_ADDR, default 32'h0000_1000, word-aligned base of the 32-byte register window.
REQ-004 SHALL have parameter DEB_CYCLES, default 12000, stable cycles for a key to change state.
REQ-005 SHALL have parameter SCAN_DIV, default 1024, clock cycles per column dwell.
REQ-006 SHALL have port clk, input, 1, the single clock.
REQ-007 SHALL have port rst, input, 1, synchronous active-high reset.
REQ-008 SHALL have port mem_valid, input, 1, bus request strobe.
REQ-009 SHALL have port mem_addr, input, 32, byte address.
REQ-010 SHALL have port mem_wdata, input, 32, write data.
REQ-011 SHALL have port mem_wstrobe, input, 1, write when 1 and read when 0.
REQ-012 SHALL have port mem_rdata, output, 32, read data.
REQ-013 SHALL have port mem_done, output, 1, one-cycle completion pulse.
REQ-014 SHALL have port keys_n, input, NKEYS, raw active-low key pins.
REQ-015 SHALL have port leds_n, output, 8, active-low row drive.
REQ-016 SHALL have port lcol_n, output, NCOL, active-low one-hot column select.

Function
REQ-017 SHALL decode a hit when mem_valid=1 and mem_addr[31:5]==BASE_ADDR[31:5]; non-hits SHALL produce no mem_done.
REQ-018 SHALL assert mem_done exactly one cycle after the hit cycle, with mem_rdata valid in that same cycle; a request held across cycles SHALL get one mem_done per hit cycle.
REQ-019 Register map (offset[4:2]):
- 0..3: LEDCOL[i] RW, bits[7:0]; i>=NCOL reads 0 and ignores writes.
- 4: KEYSTATE RO, bits[NKEYS-1:0] debounced, 1=pressed.
- 5: KEYPRESS, latched press flags, write-1-to-clear.
- 6: SCANCTRL RW, bit0 enable, bit1 invert rows.
- 7: reserved, reads 0, writes ignored.
REQ-020 Unused read bits SHALL be 0; mem_rdata SHALL be 0 whenever mem_done=0.
REQ-021 Each key SHALL pass a 2-flop synchroniser, then a per-key counter; debounced state SHALL flip only after the synchronised level differs from it for DEB_CYCLES consecutive cycles, and any bounce SHALL restart the counter at 0.
REQ-022 A 0->1 debounced transition SHALL raise a one-cycle internal press event.
REQ-023 Scan divider SHALL count 0..SCAN_DIV-1; at terminal count the column index SHALL advance, wrapping NCOL-1 -> 0.
REQ-024 In each column's first dwell cycle, leds_n SHALL be all-ones (blanking); in the remaining cycles, leds_n = ~(LEDCOL[col] ^ {8{invert}}).
REQ-025 With enable=0, lcol_n and leds_n SHALL be all-ones, and divider and column SHALL hold at 0.
REQ-026 A write to LEDCOL SHALL be visible from the next dwell cycle; no tearing within a cycle.

Reset
REQ-027 On rst: LEDCOL=0, KEYPRESS=0, SCANCTRL=0, debounced state=0, counters=0, column=0, mem_done=0, mem_rdata=0, lcol_n and leds_n all-ones.
REQ-028 rst asserted during a pending request SHALL cancel it, with no mem_done emitted.

Configuration
REQ-029 Macro SOC_MMIO_IO_KEYLATCH_EN defined: KEYPRESS SHALL behave per REQ-019; if a press event and a W1C of the same bit occur in the same cycle, set SHALL win.
REQ-030 Macro undefined: KEYPRESS SHALL read 0 and ignore writes, with no latch flops.

Structure
REQ-031 A shared package SHALL hold the register offset constants, the SCANCTRL bit indices, and the 32-bit bus data typedef.
REQ-032 Per-key debouncing SHALL be a sub-module key_debounce (sync, counter, state, press pulse), instantiated NKEYS times.

Verification
REQ-033 Write 0xA5 to LEDCOL0, then read it -> mem_done 1 cycle after each hit; read returns 0x0000_00A5.
REQ-034 Test parameters SCAN_DIV=4, NCOL=4, enable=1 -> lcol_n sequence 1110,1101,1011,0111, then wraps; first cycle of each column leds_n=0xFF.
REQ-035 Test parameter DEB_CYCLES=8; hold keys_n[0]=0 for 7 cycles, release, then hold 8 cycles -> KEYSTATE bit0 set only after the 8-cycle hold.
REQ-036 With the latch macro defined: press key2, then write KEYPRESS 0x4 in the press-event cycle -> bit2 stays 1; a later write clears it to 0.
REQ-037 Test parameter NCOL=2; write LEDCOL3=0xFF -> reads 0; an access at BASE_ADDR+0x20 -> no mem_done.
REQ-038 Assert rst during a pending read -> no mem_done; all registers read 0 afterwards.
